// File: rtl/calc_mem_arbiter_if.sv
// Bus bundle between the controller/host requesters, calc_mem_arbiter and the SRAM macro.
// slave = arbiter view, master = requester/SRAM-environment view.
interface calc_mem_arbiter_if #(
    parameter int ADDR_W        = 10,
    parameter int MEM_WORD_SIZE = 64
);
    logic                     req0_valid_i;
    logic                     req0_write_i;
    logic [ADDR_W-1:0]        req0_addr_i;
    logic [MEM_WORD_SIZE-1:0] req0_wdata_i;
    logic                     req0_ready_o;
    logic                     req1_valid_i;
    logic                     req1_write_i;
    logic [ADDR_W-1:0]        req1_addr_i;
    logic [MEM_WORD_SIZE-1:0] req1_wdata_i;
    logic                     req1_ready_o;
    logic                     host_lock_i;
    logic                     rsp0_valid_o;
    logic                     rsp1_valid_o;
    logic [MEM_WORD_SIZE-1:0] rsp_rdata_o;
    logic                     mem_read_o;
    logic                     mem_write_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [MEM_WORD_SIZE-1:0] mem_wdata_o;
    logic [MEM_WORD_SIZE-1:0] mem_rdata_i;

    modport slave (
        input  req0_valid_i, req0_write_i, req0_addr_i, req0_wdata_i,
        input  req1_valid_i, req1_write_i, req1_addr_i, req1_wdata_i,
        input  host_lock_i, mem_rdata_i,
        output req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp_rdata_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req0_valid_i, req0_write_i, req0_addr_i, req0_wdata_i,
        output req1_valid_i, req1_write_i, req1_addr_i, req1_wdata_i,
        output host_lock_i, mem_rdata_i,
        input  req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp_rdata_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/calc_mem_arbiter.sv
// Two-requester arbiter for the calculator SRAM with host lock and a read owner-tag pipeline.
// Define CALC_ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority (ctrl wins).
module calc_mem_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int MEM_WORD_SIZE = 64
) (
    input logic              clk_i,
    input logic              rst_i,
    calc_mem_arbiter_if.slave bus
);
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t               r_state;
    arb_state_t               w_state_next;
    logic [1:0]               w_valid;
    logic [1:0]               w_ready;
    logic [1:0]               w_hs;
    logic                     w_pref;
    logic                     w_sel;
    logic                     w_sel_write;
    logic [ADDR_W-1:0]        w_sel_addr;
    logic [MEM_WORD_SIZE-1:0] w_sel_wdata;
    logic                     r_mem_read;
    logic                     r_mem_write;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [MEM_WORD_SIZE-1:0] r_mem_wdata;
    logic                     r_tag_id;
    logic [1:0]               r_rsp_valid;

    assign w_valid = {bus.req1_valid_i, bus.req0_valid_i};
    assign w_hs    = w_valid & w_ready;

`ifdef CALC_ARB_ROUND_ROBIN_EN
    logic r_ptr;

    // Pointer names the requester that did not win the last handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= 1'b0;
        end else if (|w_hs) begin
            r_ptr <= w_hs[0];
        end
    end
    assign w_pref = r_ptr;
`else
    assign w_pref = 1'b0;
`endif

    always_comb begin
        w_ready      = 2'b00;
        w_state_next = r_state;
        if (!rst_i) begin
            unique case (r_state)
                ARB_OPEN: begin
                    if (w_valid == 2'b11) begin
                        w_ready[w_pref] = 1'b1;
                    end else begin
                        w_ready = w_valid;
                    end
                    if (w_valid[1] && w_ready[1] && bus.host_lock_i) begin
                        w_state_next = ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    w_ready[1] = w_valid[1];
                    if (w_valid[1] && !bus.host_lock_i) begin
                        w_state_next = ARB_OPEN;
                    end
                end
            endcase
        end
    end

    assign w_sel       = w_hs[1];
    assign w_sel_write = w_sel ? bus.req1_write_i : bus.req0_write_i;
    assign w_sel_addr  = w_sel ? bus.req1_addr_i  : bus.req0_addr_i;
    assign w_sel_wdata = w_sel ? bus.req1_wdata_i : bus.req0_wdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ARB_OPEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command register; r_mem_read doubles as the first owner-tag stage valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_tag_id    <= 1'b0;
        end else begin
            r_mem_read  <= (|w_hs) && !w_sel_write;
            r_mem_write <= (|w_hs) && w_sel_write;
            if (|w_hs) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_tag_id    <= w_sel;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_rsp_valid[gi] <= 1'b0;
                end else begin
                    r_rsp_valid[gi] <= r_mem_read && (r_tag_id == 1'(gi));
                end
            end
        end
    endgenerate

    assign bus.req0_ready_o = w_ready[0];
    assign bus.req1_ready_o = w_ready[1];
    assign bus.mem_read_o   = r_mem_read;
    assign bus.mem_write_o  = r_mem_write;
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_wdata_o  = r_mem_wdata;
    assign bus.rsp0_valid_o = r_rsp_valid[0];
    assign bus.rsp1_valid_o = r_rsp_valid[1];
    assign bus.rsp_rdata_o  = bus.mem_rdata_i;
endmodule

// File: doc/calc_mem_arbiter.md
# calc_mem_arbiter

Two-requester arbiter sharing the calculator's single-port SRAM between the calculator controller (requester 0) and the host/debug loader (requester 1). It accepts valid/ready memory commands from both requesters and issues at most one registered read or write per cycle to the SRAM. It returns read data to the requester that issued the read, and supports a host lock for uninterrupted preload/readback bursts. It sits between the controller/host and the SRAM macro.

## Interface
- ADDR_W, default calculator_pkg::ADDR_W: SRAM address width.
- MEM_WORD_SIZE, default calculator_pkg::MEM_WORD_SIZE: SRAM word width.
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: reset, asynchronous, active-high.
- req0_valid_i / req1_valid_i, input, 1: command valid from ctrl / host.
- req0_write_i / req1_write_i, input, 1: 1 = write, 0 = read.
- req0_addr_i / req1_addr_i, input, ADDR_W: command address.
- req0_wdata_i / req1_wdata_i, input, MEM_WORD_SIZE: write data.
- req0_ready_o / req1_ready_o, output, 1: grant; handshake = valid & ready.
- host_lock_i, input, 1: sampled on a host handshake; requests host ownership of the port.
- rsp0_valid_o / rsp1_valid_o, output, 1: read data valid for that requester.
- rsp_rdata_o, output, MEM_WORD_SIZE: read data, shared by both requesters.
- mem_read_o, mem_write_o, output, 1: SRAM strobes, registered.
- mem_addr_o, output, ADDR_W: SRAM address, registered.
- mem_wdata_o, output, MEM_WORD_SIZE: SRAM write data, registered.
- mem_rdata_i, input, MEM_WORD_SIZE: SRAM read data, valid the cycle after mem_read_o.

## Operation
- States:
  - ARB_OPEN: normal arbitration.
  - ARB_LOCKED: host owns the port.
- Grant in ARB_OPEN:
  - A ready is asserted only while the matching valid is high.
  - Only one ready is high per cycle.
  - The priority rule is set under Configuration.
- ARB_OPEN -> ARB_LOCKED: host handshake with host_lock_i = 1.
- ARB_LOCKED behaviour:
  - req0_ready_o = 0.
  - req1_ready_o = req1_valid_i.
- ARB_LOCKED -> ARB_OPEN: host handshake with host_lock_i = 0. That handshake still completes.
- An idle host in ARB_LOCKED holds the lock indefinitely. No timeout.
- Command register: a handshake in cycle N drives mem_read_o/mem_write_o, mem_addr_o and mem_wdata_o in cycle N+1. With no handshake, both strobes are 0 in N+1; address and data hold their previous values.
- mem_read_o and mem_write_o are never high together.
- Read return:
  - A 2-stage owner-tag pipeline carries the requester ID alongside each read.
  - rspX_valid_o is high in cycle N+2 for one cycle.
  - rsp_rdata_o = mem_rdata_i passes through combinationally.
  - Writes produce no response.
- Back-to-back: one handshake per cycle is sustained. Commands reach the SRAM in handshake order, so a write then a read to the same address returns the new data.
- Invalid address ranges are not checked. Addresses pass through unmodified.

## Timing
- Reset values: state = ARB_OPEN; strobes = 0; mem_addr_o = 0; mem_wdata_o = 0; rspX_valid_o = 0; tag pipeline cleared; round-robin pointer = requester 0.
- Readies are combinational from valids, state and pointer. Reset forces both readies to 0.
- Read latency: handshake to rsp_valid is 2 cycles. Write latency: handshake to mem_write_o is 1 cycle.
- Reset asserted mid-read clears all pending rsp_valid pulses immediately (asynchronously). No response is produced for reads in flight.
- Deasserting valid without a handshake has no effect on state or pointer.

## Configuration
- CALC_ARB_ROUND_ROBIN_EN defined:
  - Round-robin between requesters.
  - A 1-bit pointer names the preferred requester and flips to the other requester after each granted handshake.
  - On a simultaneous request, the preferred requester wins.
  - A single requester is granted every cycle regardless of the pointer.
- CALC_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: requester 0 (controller) always wins a simultaneous request.
  - The pointer register is not built.
  - The lock behaviour is identical in both builds.

## Test plan
- Reset then idle: all outputs 0. Ctrl read of addr 0x005, where SRAM holds 0xDEAD_BEEF_0000_0001 -> mem_read_o in cycle 1, rsp0_valid_o with that data in cycle 2.
- Both valid for 4 cycles, ctrl reading 0x010 and host writing 0x020:
  - With the macro: grants alternate 0,1,0,1.
  - Without the macro: ctrl granted all 4 cycles and req1_ready_o stays 0.
- Host write 0x030 = 0x1234 with lock=1, then ctrl valid for 3 cycles while the host idles:
  - req0_ready_o stays 0.
  - A host handshake with lock=0 returns to ARB_OPEN, and ctrl is granted the next cycle.
- Back-to-back host write 0x040 = 0xABCD then read 0x040 -> rsp1_valid_o 2 cycles after the read handshake with 0xABCD, and rsp0_valid_o stays 0.
- Ctrl read handshake, then rst_i asserted in the next cycle -> no rsp0_valid_o ever appears, and the state returns to ARB_OPEN.
- Continuous reads, ctrl to 0x001..0x004 interleaved with host under the macro -> every rsp valid pulse is routed to the issuing requester in order, with no gaps.
